// File: rtl/bp_nonsynth_if_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bp_nonsynth_if_monitor : passive valid/ready protocol monitor for N channels
// Revision: 1.0
// ---------------------------------------------------------------------------
module bp_nonsynth_if_monitor #(
   parameter int                       num_channels_p    = 4,
   parameter int                       data_width_p      = 64,
   parameter logic [num_channels_p-1:0] ready_then_mask_p = '0,
   parameter int                       timeout_p         = 1024,
   parameter int                       count_width_p     = 32,
   parameter bit                       fatal_on_err_p    = 1'b0,
   // Suppresses the $error/$fatal escalation; the report line is still printed.
   parameter bit                       quiet_p           = 1'b0
) (
   input  logic                                    clk_i,
   input  logic                                    reset_n_i,
   input  logic                                    en_i,
   input  logic [num_channels_p-1:0]               v_i,
   input  logic [num_channels_p-1:0]               ready_and_i,
   input  logic [num_channels_p*data_width_p-1:0]  data_i,
   output logic [num_channels_p-1:0]               err_o,
   output logic [3*num_channels_p-1:0]             err_cause_o,
   output logic [num_channels_p*count_width_p-1:0] msg_count_o,
   output logic [num_channels_p-1:0]               stall_o
);

   localparam int                        stall_width_lp = $clog2(timeout_p + 1);
   localparam logic [stall_width_lp-1:0] stall_max_lp   = stall_width_lp'(timeout_p);

   if (timeout_p == 0) begin : g_bad_timeout
      $fatal(1, "bp_nonsynth_if_monitor: timeout_p must be at least 1");
   end
   if (num_channels_p == 0) begin : g_bad_channels
      $fatal(1, "bp_nonsynth_if_monitor: num_channels_p must be at least 1");
   end
   if (data_width_p == 0) begin : g_bad_width
      $fatal(1, "bp_nonsynth_if_monitor: data_width_p must be at least 1");
   end

   for (genvar i = 0; i < num_channels_p; i++) begin : g_ch
      localparam bit ready_then_lp = ready_then_mask_p[i];

      logic                      ch_v, ch_rdy, stalled, handshake;
      logic [data_width_p-1:0]   ch_data;
      logic [2:0]                cause_now;
      logic                      pending_q, pending_d;
      logic [data_width_p-1:0]   data_q, data_d;
      logic [stall_width_lp-1:0] stall_cnt_q, stall_cnt_d;
      logic [count_width_p-1:0]  msg_cnt_q, msg_cnt_d;
      logic                      err_q, err_d;
      logic [2:0]                cause_q, cause_d;

      assign ch_v    = v_i[i];
      assign ch_rdy  = ready_and_i[i];
      assign ch_data = data_i[i*data_width_p +: data_width_p];

      always_comb begin
         stalled   = ch_v & ~ch_rdy;
         handshake = ready_then_lp ? ch_v : (ch_v & ch_rdy);

         // Priority order gives the lowest cause code when several fire together.
         cause_now = 3'd0;
         if (en_i) begin
            if (ready_then_lp) begin
               if (stalled) cause_now = 3'd3;
            end else if (pending_q & ~ch_v) begin
               cause_now = 3'd1;
            end else if (pending_q & ch_v & (ch_data != data_q)) begin
               cause_now = 3'd2;
            end else if (stalled & (stall_cnt_q == stall_max_lp)) begin
               cause_now = 3'd4;
            end
         end

         pending_d = en_i & stalled;
         data_d    = ch_v ? ch_data : data_q;

         stall_cnt_d = '0;
         if (en_i & stalled) begin
            stall_cnt_d = (stall_cnt_q == stall_max_lp) ? stall_cnt_q
                                                        : stall_cnt_q + stall_width_lp'(1);
         end

         msg_cnt_d = msg_cnt_q;
         if (en_i & handshake & (msg_cnt_q != '1)) begin
            msg_cnt_d = msg_cnt_q + count_width_p'(1);
         end

         err_d   = err_q;
         cause_d = cause_q;
         if (~err_q & (cause_now != 3'd0)) begin
            err_d   = 1'b1;
            cause_d = cause_now;
         end
      end

      always_ff @(posedge clk_i) begin
         if (!reset_n_i) begin
            pending_q   <= 1'b0;
            data_q      <= '0;
            stall_cnt_q <= '0;
            msg_cnt_q   <= '0;
            err_q       <= 1'b0;
            cause_q     <= 3'd0;
         end else begin
            pending_q   <= pending_d;
            data_q      <= data_d;
            stall_cnt_q <= stall_cnt_d;
            msg_cnt_q   <= msg_cnt_d;
            err_q       <= err_d;
            cause_q     <= cause_d;
         end
      end

      // Reports only on the cycle the first error latches.
      always @(posedge clk_i) begin
         if (reset_n_i && !err_q && (cause_now != 3'd0)) begin
            $info("%m ch %0d cause %0d time %0t", i, cause_now, $time);
            if (!quiet_p) begin
               if (fatal_on_err_p) $fatal(1, "%m ch %0d protocol error cause %0d", i, cause_now);
               else                $error("%m ch %0d protocol error cause %0d", i, cause_now);
            end
         end
      end

      final begin
         $info("%m ch %0d msgs %0d err %0b cause %0d", i, msg_cnt_q, err_q, cause_q);
      end

      assign err_o[i]                                   = err_q;
      assign err_cause_o[3*i +: 3]                      = cause_q;
      assign msg_count_o[i*count_width_p +: count_width_p] = msg_cnt_q;
      assign stall_o[i]                                 = (stall_cnt_q != '0);
   end

endmodule
`default_nettype wire
